// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl: sequences the entropy sampler through warm-up, decimates the
// synchronized bit stream into words, runs a repetition-count health test on the
// raw ticked bits, and hands words downstream over valid/ready.
// Optional build macro: TRNG_VON_NEUMANN_EN enables pairwise Von Neumann debiasing.
module trng_sample_ctrl #(
    parameter int unsigned WORD_W        = 32,
    parameter int unsigned WARMUP_CYCLES = 3,
    parameter int unsigned SAMPLE_DIV    = 4,
    parameter int unsigned REP_LIMIT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              sampled_bit,
    output logic              sampler_en,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              health_fail
);
    localparam int unsigned CNT_W  = $clog2(WORD_W + 1);
    localparam int unsigned REP_W  = $clog2(REP_LIMIT + 1);
    localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int unsigned SHR_W  = WORD_W - 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_HOLD,
        S_FAIL
    } state_t;

    state_t             state, state_d;
    logic [WARM_W-1:0]  warm_cnt, warm_cnt_d;
    logic [DIV_W-1:0]   div_cnt, div_cnt_d;
    logic [CNT_W-1:0]   bitcnt, bitcnt_d;
    logic [REP_W-1:0]   repcnt, repcnt_d;
    logic               last_bit, last_bit_d;
    // Only WORD_W-1 bits are stored; the final bit goes straight into word_data.
    logic [SHR_W-1:0]   shreg, shreg_d;
    logic [WORD_W-1:0]  word_data_d;
    logic               word_valid_d;
    logic               sampler_en_d;
    logic               busy_d;
    logic               health_fail_d;
`ifdef TRNG_VON_NEUMANN_EN
    logic               pair_phase, pair_phase_d;
    logic               first_bit, first_bit_d;
`endif

    logic               tick;
    logic               emit;
    logic               emit_bit;
    logic [REP_W-1:0]   rep_nxt;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d       = state;
        warm_cnt_d    = warm_cnt;
        div_cnt_d     = div_cnt;
        bitcnt_d      = bitcnt;
        repcnt_d      = repcnt;
        last_bit_d    = last_bit;
        shreg_d       = shreg;
        word_data_d   = word_data;
        word_valid_d  = word_valid;
        sampler_en_d  = 1'b0;
        busy_d        = 1'b0;
        health_fail_d = 1'b0;
        tick          = 1'b0;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        rep_nxt       = '0;
`ifdef TRNG_VON_NEUMANN_EN
        pair_phase_d  = pair_phase;
        first_bit_d   = first_bit;
`endif

        case (state)
            S_IDLE: begin
                warm_cnt_d   = '0;
                div_cnt_d    = '0;
                bitcnt_d     = '0;
                repcnt_d     = '0;
                last_bit_d   = 1'b0;
                shreg_d      = '0;
                word_valid_d = 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
                pair_phase_d = 1'b0;
`endif
                if (run) begin
                    state_d = S_WARMUP;
                end
            end

            S_WARMUP: begin
                repcnt_d = '0;
`ifdef TRNG_VON_NEUMANN_EN
                pair_phase_d = 1'b0;
`endif
                if (!run) begin
                    state_d = S_IDLE;
                end else if (warm_cnt == WARM_LAST) begin
                    state_d = S_COLLECT;
                end else begin
                    warm_cnt_d = warm_cnt + WARM_W'(1);
                end
            end

            S_COLLECT: begin
                tick      = (div_cnt == DIV_LAST);
                div_cnt_d = tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) begin
                    rep_nxt    = ((repcnt == '0) || (sampled_bit != last_bit)) ?
                                 REP_W'(1) : repcnt + REP_W'(1);
                    repcnt_d   = rep_nxt;
                    last_bit_d = sampled_bit;
`ifdef TRNG_VON_NEUMANN_EN
                    pair_phase_d = ~pair_phase;
                    if (!pair_phase) begin
                        first_bit_d = sampled_bit;
                    end else if (first_bit != sampled_bit) begin
                        emit     = 1'b1;
                        emit_bit = first_bit;
                    end
`else
                    emit     = 1'b1;
                    emit_bit = sampled_bit;
`endif
                    if (emit) begin
                        shreg_d  = SHR_W'({shreg, emit_bit});
                        bitcnt_d = bitcnt + CNT_W'(1);
                    end
                end
                if (tick && (rep_nxt == REP_MAX)) begin
                    state_d = S_FAIL;
                end else if (!run) begin
                    state_d = S_IDLE;
                end else if (emit && (bitcnt == BIT_LAST)) begin
                    state_d      = S_HOLD;
                    word_data_d  = {shreg, emit_bit};
                    word_valid_d = 1'b1;
                    bitcnt_d     = '0;
                end
            end

            S_HOLD: begin
                div_cnt_d = '0;
                if (word_valid && word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = run ? S_COLLECT : S_IDLE;
                end
            end

            S_FAIL: begin
                word_valid_d = 1'b0;
            end

            default: begin
                state_d      = S_IDLE;
                word_valid_d = 1'b0;
            end
        endcase

        sampler_en_d  = (state_d == S_WARMUP) || (state_d == S_COLLECT) || (state_d == S_HOLD);
        busy_d        = sampler_en_d;
        health_fail_d = (state_d == S_FAIL);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            warm_cnt    <= '0;
            div_cnt     <= '0;
            bitcnt      <= '0;
            repcnt      <= '0;
            last_bit    <= 1'b0;
            shreg       <= '0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            sampler_en  <= 1'b0;
            busy        <= 1'b0;
            health_fail <= 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
            pair_phase  <= 1'b0;
            first_bit   <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            warm_cnt    <= warm_cnt_d;
            div_cnt     <= div_cnt_d;
            bitcnt      <= bitcnt_d;
            repcnt      <= repcnt_d;
            last_bit    <= last_bit_d;
            shreg       <= shreg_d;
            word_data   <= word_data_d;
            word_valid  <= word_valid_d;
            sampler_en  <= sampler_en_d;
            busy        <= busy_d;
            health_fail <= health_fail_d;
`ifdef TRNG_VON_NEUMANN_EN
            pair_phase  <= pair_phase_d;
            first_bit   <= first_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Testbench for trng_sample_ctrl: WORD_W=8, WARMUP_CYCLES=3, SAMPLE_DIV=2, REP_LIMIT=6.
// Delivered words are scored against a queue of expected words.
module tb_trng_sample_ctrl;
    localparam int W    = 8;
    localparam int WARM = 3;
    localparam int DIV  = 2;
    localparam int REP  = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         sampled_bit;
    logic         sampler_en;
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         word_ready;
    logic         busy;
    logic         health_fail;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    trng_sample_ctrl #(
        .WORD_W(W),
        .WARMUP_CYCLES(WARM),
        .SAMPLE_DIV(DIV),
        .REP_LIMIT(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .sampled_bit(sampled_bit),
        .sampler_en(sampler_en),
        .word_data(word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy(busy),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got %h, required no word", word_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (word_data !== exp_w) begin
                    errors++;
                    $display("FAIL word_data: got %h, required %h", word_data, exp_w);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_bit(input logic b);
        sampled_bit = b;
        repeat (DIV) step();
    endtask

    task automatic feed_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) tick_bit(w[W-1-i]);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; word_ready = 1'b1; sampled_bit = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        step();
        repeat (WARM) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sampler_en !== 1'b0) begin errors++; $display("FAIL rst_sampler_en: got %b required 0", sampler_en); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_word_valid: got %b required 0", word_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL rst_health_fail: got %b required 0", health_fail); end
        checks++; if (word_data !== 8'h00) begin errors++; $display("FAIL rst_word_data: got %h required 00", word_data); end
    endtask

`ifdef TRNG_VON_NEUMANN_EN
    task automatic test_vn();
        do_reset();
        start_run();
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 2 * W - 1; i++) tick_bit((i % 2) == 0);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL vn_early_valid: got %b required 0", word_valid); end
        tick_bit(1'b0);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL vn_valid: got %b required 1", word_valid); end
        step();
        for (int i = 0; i < 40; i++) begin
            tick_bit((i % 4) < 2);
            if ((i % 4) == 3) begin
                checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL vn_1100_valid: got %b required 0", word_valid); end
                checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL vn_1100_health: got %b required 0", health_fail); end
            end
        end
        exp_q.push_back(8'h00);
        for (int i = 0; i < 2 * W; i++) tick_bit((i % 2) == 1);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL vn_zero_valid: got %b required 1", word_valid); end
        step();
    endtask
`else
    task automatic test_startup_word();
        logic [W-1:0] v;
        do_reset();
        run = 1'b1;
        checks++; if (sampler_en !== 1'b0) begin errors++; $display("FAIL start_en_pre: got %b required 0", sampler_en); end
        step();
        checks++; if (sampler_en !== 1'b1) begin errors++; $display("FAIL start_en: got %b required 1", sampler_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b required 1", busy); end
        repeat (WARM) step();
        v = 8'hAA;
        exp_q.push_back(v);
        feed_bits(v, W - 1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL word_early_valid: got %b required 0", word_valid); end
        tick_bit(v[0]);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL word_valid: got %b required 1", word_valid); end
        checks++; if (word_data !== 8'hAA) begin errors++; $display("FAIL word_hold_data: got %h required aa", word_data); end
        step();
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL word_valid_drop: got %b required 0", word_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL word_busy: got %b required 1", busy); end
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        exp_q.push_back(8'hAA);
        feed_bits(8'hAA, W);
        sampled_bit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", i, word_valid); end
            checks++; if (word_data !== 8'hAA) begin errors++; $display("FAIL bp_data[%0d]: got %h required aa", i, word_data); end
            step();
        end
        word_ready = 1'b1;
        step();
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b required 0", word_valid); end
        exp_q.push_back(8'h5A);
        feed_bits(8'h5A, W);
        checks++; if (word_data !== 8'h5A) begin errors++; $display("FAIL bp_next_data: got %h required 5a", word_data); end
        step();
        exp_q.push_back(8'hFA);
        feed_bits(8'hFA, W);
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL rep5_health: got %b required 0", health_fail); end
        step();
    endtask

    task automatic test_health();
        do_reset();
        start_run();
        repeat (REP - 1) tick_bit(1'b1);
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL hf_early: got %b required 0", health_fail); end
        tick_bit(1'b1);
        checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL hf_set: got %b required 1", health_fail); end
        checks++; if (sampler_en !== 1'b0) begin errors++; $display("FAIL hf_sampler_en: got %b required 0", sampler_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hf_busy: got %b required 0", busy); end
        for (int i = 0; i < 8; i++) begin
            run = i[0];
            step();
            checks++; if (health_fail !== 1'b1 || sampler_en !== 1'b0 || word_valid !== 1'b0)
                begin errors++; $display("FAIL hf_sticky[%0d]: got hf=%b en=%b v=%b required 1 0 0", i, health_fail, sampler_en, word_valid); end
        end
        do_reset();
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL hf_rst_clear: got %b required 0", health_fail); end
        // Failing tick that also completes a word: no word presented.
        start_run();
        feed_bits(8'hBF, W);
        checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL hf_on_complete: got %b required 1", health_fail); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL hf_complete_valid: got %b required 0", word_valid); end
        // Repetition count carries across a delivered word.
        do_reset();
        start_run();
        exp_q.push_back(8'hA7);
        feed_bits(8'hA7, W);
        step();
        tick_bit(1'b1);
        tick_bit(1'b1);
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL persist_early: got %b required 0", health_fail); end
        tick_bit(1'b1);
        checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL persist_fail: got %b required 1", health_fail); end
    endtask

    task automatic test_abort();
        do_reset();
        start_run();
        feed_bits(8'hA8, 5);
        run = 1'b0;
        step();
        checks++; if (sampler_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got en=%b busy=%b required 0 0", sampler_en, busy); end
        repeat (3) step();
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL abort_no_word: got %b required 0", word_valid); end
        start_run();
        exp_q.push_back(8'h3C);
        feed_bits(8'h3C, W);
        checks++; if (word_valid !== 1'b1 || word_data !== 8'h3C) begin errors++; $display("FAIL restart_word: got v=%b d=%h required 1 3c", word_valid, word_data); end
        step();
        word_ready = 1'b0;
        exp_q.push_back(8'h96);
        feed_bits(8'h96, W);
        run = 1'b0;
        repeat (3) step();
        checks++; if (word_valid !== 1'b1 || sampler_en !== 1'b1) begin errors++; $display("FAIL hold_runlow: got v=%b en=%b required 1 1", word_valid, sampler_en); end
        word_ready = 1'b1;
        step();
        checks++; if (word_valid !== 1'b0 || busy !== 1'b0 || sampler_en !== 1'b0) begin errors++; $display("FAIL hold_to_idle: got v=%b busy=%b en=%b required 0 0 0", word_valid, busy, sampler_en); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        start_run();
        word_ready = 1'b0;
        feed_bits(8'h69, W);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rh_valid: got %b required 1", word_valid); end
        rst = 1'b1;
        step();
        checks++; if (word_valid !== 1'b0 || word_data !== 8'h00 || sampler_en !== 1'b0)
            begin errors++; $display("FAIL rh_cleared: got v=%b d=%h en=%b required 0 00 0", word_valid, word_data, sampler_en); end
        rst = 1'b0;
        word_ready = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
`ifdef TRNG_VON_NEUMANN_EN
        test_vn();
`else
        test_startup_word();
        test_backpressure();
        test_health();
        test_abort();
        test_reset_in_hold();
`endif
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL words_pending: got %0d undelivered, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
